clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable clock divider. It generalises the fixed-ratio divider: counter width is a parameter, and the divide ratio and high time (duty cycle) are loaded at runtime through a valid/ready config port. Config changes, start and stop all take effect only at period boundaries, so the output never glitches. It sits between a control register block and consumers that need a derived clock (e.g. UART baud, SPI SCLK) or single-cycle enable strobes.

## Interface
- CNT_WIDTH, 16, width of the period counter and of the cfg_div/cfg_high fields; must be ≥2.
- DEFAULT_DIV, 5208, divide ratio after reset; must satisfy 2 ≤ DEFAULT_DIV < 2**CNT_WIDTH.
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  run request; sampled every cycle.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config slot free.
- cfg_div  in  CNT_WIDTH  requested period D, in clk cycles.
- cfg_high  in  CNT_WIDTH  requested high time H, in clk cycles.
- cfg_err  out  1  one-cycle pulse: accepted config was illegal and was discarded.
- new_clk  out  1  divided clock, registered.
- tick_rise  out  1  one-cycle strobe coincident with a new_clk rising edge.
- tick_fall  out  1  one-cycle strobe coincident with a new_clk falling edge.
- running  out  1  high in RUN state.

## Operation
- Active config is Da/Ha; pending config is Dp/Hp plus a valid bit pv. The period counter is cnt.
- Reset state:
  - Da=DEFAULT_DIV, Ha=DEFAULT_DIV/2 (floor), pv=0, cnt=0, state IDLE.
  - Outputs: new_clk=0, ticks=0, cfg_err=0, running=0, cfg_ready=1.
- cfg_ready = !pv (combinational from pv). A transfer occurs when cfg_valid && cfg_ready at a rising clk.
- Transfer with cfg_div < 2: config discarded, cfg_err=1 next cycle, pv unchanged.
- Transfer with a legal config:
  - In IDLE: Da/Ha load next cycle; pv stays 0.
  - In RUN: Dp/Hp load and pv=1.
- Ha ≥ Da means constant high; Ha=0 means constant low. Neither is an error.
- FSM:
  - IDLE: cnt=0, new_clk=0. If en=1, go to RUN next cycle with cnt=0.
  - RUN: cnt increments each cycle. When cnt==Da-1 (wrap):
    - cnt←0.
    - If pv, then Da←Dp, Ha←Hp, pv←0.
    - If en=0, go to IDLE; otherwise stay in RUN.
  - en may drop and return before the wrap with no effect. A period is never truncated.
- new_clk in any RUN cycle equals (cnt < Ha), using that cycle's cnt and Ha. It is driven from a register computed on next-state values.
- tick_rise=1 in RUN cycles where new_clk=1 and either the previous cycle's new_clk=0 or the previous cycle was IDLE. tick_fall mirrors this for falling edges, including the fall caused by entering IDLE.
- Arithmetic is unsigned, CNT_WIDTH bits wide. Comparisons use ==/<, never a widened subtraction. cnt never exceeds Da-1.

## Timing
- Start: en sampled high in IDLE at edge N → running=1, cnt=0, new_clk=(Ha>0) from edge N+1.
- Period = Da cycles exactly, high for min(Ha,Da) cycles, starting at cnt=0.
- Config latency:
  - IDLE: 1 cycle.
  - RUN: applied at the first wrap after acceptance. The first new period begins with the new values. cfg_ready returns 1 the cycle after the wrap.
- Simultaneous wrap and cfg transfer: the transfer is to the pending slot only if pv=0, and it is applied at the next wrap, not the current one.
- Stop: en=0 at the wrap edge → IDLE, new_clk=0, running=0 on the following cycle.
- Asynchronous reset mid-period: all state and outputs go to reset values immediately. Any pending config is lost.

## Test plan
- Reset defaults: after release, DEFAULT_DIV=5208 and en=1 give a period of 5208 cycles with 2604 high, and tick_rise every 5208 cycles.
- In IDLE, write D=4 H=1 then set en=1 → new_clk pattern 1000 repeating, tick_rise at cnt=0, tick_fall at cnt=1.
- Running D=4 H=2, write D=6 H=3 at cnt=1:
  - cfg_ready stays low until the wrap.
  - A full 4-cycle period completes, then 6-cycle periods with 3 high.
  - A second offer is stalled until the wrap.
- Write D=1 → cfg_err single pulse, waveform unchanged. Write D=5 H=0 → new_clk constant low with no ticks. Write D=5 H=7 → constant high.
- Running D=8, drop en at cnt=2 → 5 more RUN cycles, then IDLE with new_clk=0. Pulse en low for 1 cycle mid-period → no stop.
- Assert rst at cnt=3 with a pending config → outputs go to reset values immediately. On restart, period=DEFAULT_DIV and the pending config is not applied.

Source files
------------

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//
// Runtime-programmable clock divider. Produces a registered divided clock
// (new_clk) plus single-cycle strobes on its rising and falling edges. The
// period D and high time H are loaded through a valid/ready config port.
// Start, stop and config changes only take effect on period boundaries, so
// new_clk never glitches or truncates a period.
//
// Parameters
//   CNT_WIDTH    width of the period counter and of cfg_div/cfg_high (>= 2)
//   DEFAULT_DIV  divide ratio after reset, 2 <= DEFAULT_DIV < 2**CNT_WIDTH;
//                the high time after reset is DEFAULT_DIV/2
//
// Ports
//   clk        single clock
//   rst        asynchronous active-high reset
//   en         run request, sampled every cycle; a stop is honoured at the
//              end of the current period only
//   cfg_valid  config offer
//   cfg_ready  config slot free (pending slot empty)
//   cfg_div    requested period D in clk cycles (D < 2 is rejected)
//   cfg_high   requested high time H in clk cycles (H = 0 constant low,
//              H >= D constant high)
//   cfg_err    one-cycle pulse: accepted config was illegal and discarded
//   new_clk    divided clock, registered
//   tick_rise  one-cycle strobe coincident with a new_clk rising edge
//   tick_fall  one-cycle strobe coincident with a new_clk falling edge
//   running    high while in RUN
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | counter parked at 0, new_clk low; configs load straight into
//       | the active registers
// RUN   | counter sweeps 0..Da-1; configs wait in the pending slot and
//       | are applied at the wrap
// -----------------------------------------------------------------------------
module clk_div_prog #(
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = 5208
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CNT_WIDTH-1:0] cfg_div,
   input  logic [CNT_WIDTH-1:0] cfg_high,
   output logic                 cfg_err,
   output logic                 new_clk,
   output logic                 tick_rise,
   output logic                 tick_fall,
   output logic                 running
);

   localparam logic [CNT_WIDTH-1:0] DEF_DIV  = CNT_WIDTH'(DEFAULT_DIV);
   localparam logic [CNT_WIDTH-1:0] DEF_HIGH = CNT_WIDTH'(DEFAULT_DIV / 2);
   localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] MIN_DIV  = CNT_WIDTH'(2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] div_a_q, div_a_d;
   logic [CNT_WIDTH-1:0] high_a_q, high_a_d;
   logic [CNT_WIDTH-1:0] div_p_q, div_p_d;
   logic [CNT_WIDTH-1:0] high_p_q, high_p_d;
   logic                 pv_q, pv_d;
   logic                 new_clk_q, new_clk_d;
   logic                 tick_rise_q, tick_rise_d;
   logic                 tick_fall_q, tick_fall_d;
   logic                 cfg_err_q, cfg_err_d;

   logic                 xfer;
   logic                 cfg_bad;
   logic                 cfg_ok;
   logic                 wrap;

   // A transfer can only happen while the pending slot is empty, so a wrap
   // that consumes the pending slot never coincides with a new offer
   // landing in it.
   assign cfg_ready = !pv_q;
   assign xfer      = cfg_valid && !pv_q;
   assign cfg_bad   = cfg_div < MIN_DIV;
   assign cfg_ok    = xfer && !cfg_bad;
   assign wrap      = (state_q == ST_RUN) && (cnt_q == div_a_q - ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         div_a_q     <= DEF_DIV;
         high_a_q    <= DEF_HIGH;
         div_p_q     <= '0;
         high_p_q    <= '0;
         pv_q        <= 1'b0;
         new_clk_q   <= 1'b0;
         tick_rise_q <= 1'b0;
         tick_fall_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_a_q     <= div_a_d;
         high_a_q    <= high_a_d;
         div_p_q     <= div_p_d;
         high_p_q    <= high_p_d;
         pv_q        <= pv_d;
         new_clk_q   <= new_clk_d;
         tick_rise_q <= tick_rise_d;
         tick_fall_q <= tick_fall_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_a_d   = div_a_q;
      high_a_d  = high_a_q;
      div_p_d   = div_p_q;
      high_p_d  = high_p_q;
      pv_d      = pv_q;
      cfg_err_d = xfer && cfg_bad;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (cfg_ok) begin
               div_a_d  = cfg_div;
               high_a_d = cfg_high;
            end
            if (en) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (wrap) begin
               cnt_d = '0;
               if (pv_q) begin
                  div_a_d  = div_p_q;
                  high_a_d = high_p_q;
                  pv_d     = 1'b0;
               end
               if (!en) begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
            // Offers accepted on the wrap edge land in the pending slot and
            // wait for the following wrap.
            if (cfg_ok) begin
               div_p_d  = cfg_div;
               high_p_d = cfg_high;
               pv_d     = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from next-state values so new_clk lines up
      // with the counter value it describes. Entering IDLE forces new_clk
      // low, which naturally produces the trailing tick_fall.
      new_clk_d   = (state_d == ST_RUN) && (cnt_d < high_a_d);
      tick_rise_d = new_clk_d && !new_clk_q;
      tick_fall_d = !new_clk_d && new_clk_q;
   end

   assign new_clk   = new_clk_q;
   assign tick_rise = tick_rise_q;
   assign tick_fall = tick_fall_q;
   assign cfg_err   = cfg_err_q;
   assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

   localparam int W   = 16;
   localparam int DEF = 5208;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic [W-1:0] cfg_high = '0;
   logic         cfg_ready;
   logic         cfg_err;
   logic         new_clk;
   logic         tick_rise;
   logic         tick_fall;
   logic         running;

   clk_div_prog #(.CNT_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_err   (cfg_err),
      .new_clk   (new_clk),
      .tick_rise (tick_rise),
      .tick_fall (tick_fall),
      .running   (running)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference model: the divider as a phase position within a period of
   // m_da cycles, with configs waiting in a queue until the period ends.
   typedef struct {
      int d;
      int h;
   } cfg_t;

   bit   m_run;
   int   m_pos;
   int   m_da;
   int   m_ha;
   cfg_t m_pend[$];
   bit   m_clk;
   bit   m_rise;
   bit   m_fall;
   bit   m_err;

   function automatic void model_reset();
      m_run  = 1'b0;
      m_pos  = 0;
      m_da   = DEF;
      m_ha   = DEF / 2;
      m_pend.delete();
      m_clk  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_err  = 1'b0;
   endfunction

   function automatic void model_step();
      bit   ready;
      bit   xfer;
      bit   legal;
      bit   clk_prev;
      cfg_t c;
      ready    = (m_pend.size() == 0);
      xfer     = cfg_valid && ready;
      legal    = xfer && (int'(cfg_div) >= 2);
      clk_prev = m_clk;
      m_err    = xfer && (int'(cfg_div) < 2);
      if (!m_run) begin
         if (legal) begin
            m_da = int'(cfg_div);
            m_ha = int'(cfg_high);
         end
         if (en) begin
            m_run = 1'b1;
            m_pos = 0;
         end
      end else begin
         if (m_pos == m_da - 1) begin
            m_pos = 0;
            if (m_pend.size() > 0) begin
               c    = m_pend.pop_front();
               m_da = c.d;
               m_ha = c.h;
            end
            if (!en) m_run = 1'b0;
         end else begin
            m_pos++;
         end
         if (legal) begin
            c.d = int'(cfg_div);
            c.h = int'(cfg_high);
            m_pend.push_back(c);
         end
      end
      m_clk  = m_run && (m_pos < m_ha);
      m_rise = m_clk && !clk_prev;
      m_fall = !m_clk && clk_prev;
   endfunction

   function automatic void check_all();
      chk("new_clk", new_clk, m_clk);
      chk("tick_rise", tick_rise, m_rise);
      chk("tick_fall", tick_fall, m_fall);
      chk("running", running, m_run);
      chk("cfg_ready", cfg_ready, m_pend.size() == 0);
      chk("cfg_err", cfg_err, m_err);
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic offer(input int d, input int h);
      cfg_div   = W'(d);
      cfg_high  = W'(h);
      cfg_valid = 1'b1;
      cycle();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string name);
      int k;
      en = 1'b0;
      k  = 0;
      while (running === 1'b1 && k < max) begin
         cycle();
         k++;
      end
      chk({name, " stop"}, running, 0);
   endtask

   task automatic check_default(input string name);
      int highs;
      int first_r;
      int second_r;
      highs    = 0;
      first_r  = -1;
      second_r = -1;
      en = 1'b1;
      cycle();
      for (int k = 0; k <= DEF; k++) begin
         if (k < DEF && new_clk === 1'b1) highs++;
         if (tick_rise === 1'b1) begin
            if (first_r < 0) first_r = k;
            else if (second_r < 0) second_r = k;
         end
         cycle();
      end
      chk({name, " high"}, highs, DEF / 2);
      chk({name, " first rise"}, first_r, 0);
      chk({name, " period"}, second_r - first_r, DEF);
      wait_idle(2 * DEF + 4, name);
   endtask

   typedef struct {
      int div;
      int high;
      bit err;
      int per;
      int hi;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int highs;
      int rises;
      int falls;
      int exp_r;
      int exp_f;
      int runs;
      int lows;
      int k;
      logic [15:0] wave;

      vecs[0] = '{4, 1, 1'b0, 4, 1};
      vecs[1] = '{4, 2, 1'b0, 4, 2};
      vecs[2] = '{6, 3, 1'b0, 6, 3};
      vecs[3] = '{2, 1, 1'b0, 2, 1};
      vecs[4] = '{5, 0, 1'b0, 5, 0};
      vecs[5] = '{5, 7, 1'b0, 5, 5};
      vecs[6] = '{1, 0, 1'b1, 5, 5};
      vecs[7] = '{0, 3, 1'b1, 5, 5};
      vecs[8] = '{3, 2, 1'b0, 3, 2};
      vecs[9] = '{7, 6, 1'b0, 7, 6};

      // Power-on reset.
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      check_default("default");

      // Table: each config loaded in IDLE, two full periods observed.
      foreach (vecs[i]) begin
         offer(vecs[i].div, vecs[i].high);
         chk("vec cfg_err", cfg_err, vecs[i].err);
         en = 1'b1;
         cycle();
         highs = 0;
         rises = 0;
         falls = 0;
         for (int j = 0; j < 2 * vecs[i].per; j++) begin
            if (new_clk === 1'b1) highs++;
            if (tick_rise === 1'b1) rises++;
            if (tick_fall === 1'b1) falls++;
            cycle();
         end
         exp_r = (vecs[i].hi == 0) ? 0 : ((vecs[i].hi >= vecs[i].per) ? 1 : 2);
         exp_f = (vecs[i].hi > 0 && vecs[i].hi < vecs[i].per) ? 2 : 0;
         chk("vec high cycles", highs, 2 * vecs[i].hi);
         chk("vec rises", rises, exp_r);
         chk("vec falls", falls, exp_f);
         wait_idle(2 * vecs[i].per + 4, "vec");
      end

      // Running D=4 H=2, offer D=6 H=3 at cnt=1, second offer D=3 H=1 stalled.
      offer(4, 2);
      en = 1'b1;
      cycle();
      wave[15] = new_clk;
      cycle();
      wave[14] = new_clk;
      cfg_div   = W'(6);
      cfg_high  = W'(3);
      cfg_valid = 1'b1;
      cycle();
      wave[13] = new_clk;
      chk("reconfig ready cnt2", cfg_ready, 0);
      cfg_div  = W'(3);
      cfg_high = W'(1);
      cycle();
      wave[12] = new_clk;
      chk("reconfig ready cnt3", cfg_ready, 0);
      cycle();
      wave[11] = new_clk;
      chk("reconfig ready after wrap", cfg_ready, 1);
      cycle();
      cfg_valid = 1'b0;
      wave[10] = new_clk;
      chk("second offer taken", cfg_ready, 0);
      for (int i = 9; i >= 0; i--) begin
         cycle();
         wave[i] = new_clk;
      end
      chk("reconfig waveform", wave, 16'b1100_1110_0010_0100);

      // Illegal divide while running: single error pulse, waveform kept.
      offer(1, 0);
      chk("run err pulse", cfg_err, 1);
      cycle();
      chk("run err single", cfg_err, 0);
      repeat (6) cycle();
      wait_idle(10, "err run");

      // Stop request at cnt=2 of an 8-cycle period.
      offer(8, 4);
      en = 1'b1;
      repeat (3) cycle();
      en   = 1'b0;
      runs = 0;
      k    = 0;
      cycle();
      while (running === 1'b1 && k < 20) begin
         runs++;
         cycle();
         k++;
      end
      chk("stop tail cycles", runs, 5);
      chk("stop new_clk", new_clk, 0);

      // One-cycle en glitch mid-period: must not stop.
      en = 1'b1;
      repeat (3) cycle();
      en = 1'b0;
      cycle();
      en   = 1'b1;
      lows = 0;
      for (int j = 0; j < 16; j++) begin
         cycle();
         if (running !== 1'b1) lows++;
      end
      chk("en glitch no stop", lows, 0);
      wait_idle(20, "glitch");

      // Async reset at cnt=3 with a pending config.
      offer(8, 4);
      en = 1'b1;
      cycle();
      cfg_div   = W'(3);
      cfg_high  = W'(1);
      cfg_valid = 1'b1;
      cycle();
      cfg_valid = 1'b0;
      chk("pending held", cfg_ready, 0);
      cycle();
      cycle();
      chk("pre-reset high", new_clk, 1);
      #2;
      rst = 1'b1;
      en  = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("reset new_clk", new_clk, 0);
      chk("reset ready", cfg_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      check_default("restart");

      // Randomised traffic against the model.
      offer(5, 2);
      for (int j = 0; j < 3000; j++) begin
         en        = ($urandom_range(0, 7) != 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_div   = W'($urandom_range(0, 9));
         cfg_high  = W'($urandom_range(0, 10));
         cycle();
      end
      cfg_valid = 1'b0;
      wait_idle(40, "random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
